dma_channel_sequencer: RTL and testbench
========================================

// Module: dma_channel_sequencer
// PURPOSE
//  Control FSM for the 4-channel DMA datapath. Arbitrates DREQ and software requests per channel.
//  Runs the HRQ/HLDA bus handshake and steps S1-S4 per word.
//  Drives ld_temp_addr, ld_upper_address, ld_lower_address and addr_gen into the datapath,
//  plus DACK and the bus strobes.
//  Consumes tc, is_read, mode and priority bits from the datapath registers.
// PARAMETERS
//  NUM_CH  4  number of channels; fixed at 4 in this revision
//  CH_W    2  channel index width; must equal clog2(NUM_CH)
// PORTS
//  clk                input   1       system clock
//  rst                input   1       asynchronous, active-high reset
//  master_clr         input   1       software master clear; synchronous; same effect as rst
//  cs_n               input   1       0 = CPU programming cycle; no new service starts while 0
//  dreq               input   NUM_CH  hardware requests, active high, level
//  request_reg        input   NUM_CH  software request bits from datapath
//  mask_reg           input   NUM_CH  1 = hardware request masked
//  rotating_priority  input   1       1 = rotating priority, 0 = fixed (ch0 highest)
//  xfer_mode          input   2       mode of granted channel: 00 demand, 01 single, 10 block, 11 treated as single
//  is_read            input   1       1 = memory-to-IO, 0 = IO-to-memory
//  tc                 input   1       terminal count from datapath, sampled in S4
//  hlda               input   1       hold acknowledge from CPU
//  hrq                output  1       hold request
//  aen                output  1       address enable; high in S1-S4
//  dack               output  NUM_CH  one-hot acknowledge for active channel
//  active_ch          output  CH_W    granted channel index
//  ld_temp_addr       output  1       load temp addr/count regs from current regs
//  ld_upper_address   output  1       drive A[15:8] onto data bus
//  ld_lower_address   output  1       drive A[7:0]; write back temp to current regs
//  addr_gen           output  1       increment/decrement address, decrement count
//  memr_n, memw_n     output  1 each  memory strobes, active low
//  ior_n, iow_n       output  1 each  IO strobes, active low
//  clr_sw_req         output  NUM_CH  one-cycle pulse clearing software request at termination
//  eop_out            output  1       one-cycle end-of-process pulse
// BEHAVIOUR
//  Reset:
//   - rst (async) or master_clr (sync) -> state SI, priority pointer = ch0.
//   - All strobes 1; all other outputs 0. Applies mid-transfer with no completion of the word.
//  Effective request: eff = (dreq & ~mask_reg) | request_reg. Software requests ignore the mask.
//   A software-only grant always runs block mode.
//  Arbitration:
//   - Performed only in SI. Fixed: lowest index wins.
//   - Rotating: search starts one above the last terminated channel.
//   - Pointer updates only on termination.
//  FSM:
//   SI  idle. eff != 0 and cs_n = 1 -> latch winner into active_ch -> S0.
//   S0  hrq = 1.
//       - hlda = 1 -> S1.
//       - eff[active_ch] = 0 before hlda -> SI; hrq drops the next cycle.
//   S1  aen = 1, ld_upper_address = 1. ld_temp_addr = 1 on the first word of a service only.
//   S2  ld_lower_address = 1; dack[active_ch] = 1; read strobe asserted.
//       is_read = 1 -> memr_n; is_read = 0 -> ior_n.
//   S3  dack held; write strobe asserted.
//       is_read = 1 -> iow_n; is_read = 0 -> memw_n.
//   S4  dack and strobes held; addr_gen = 1 for exactly one cycle; next state decided here:
//       - tc = 1 -> eop_out, clr_sw_req[active_ch], pointer update -> SI.
//       - hlda = 0 -> SI, no eop; word completes, nothing lost.
//       - single -> SI. hrq drops; bus returned after each word.
//       - demand -> S1 if dreq[active_ch] = 1, else SI.
//       - block -> S1.
//  Timing:
//   - Four clocks per word. hrq stays high S0-S4 and across S4 -> S1 loops.
//   - All outputs are registered-state decodes; no combinational path from inputs to strobes.
//  Corner cases:
//   - tc and a demand drop in the same S4: tc wins.
//   - Requests arriving during a service wait for SI. The active channel is never preempted.
// CONFIGURATION
//  EXT_EOP_EN defined:
//   - Adds input eop_in_n (active low, 2-flop synchronised).
//   - Sampled low in S2-S4 terminates at S4 exactly as tc = 1.
//  EXT_EOP_EN undefined:
//   - Port absent; only tc terminates.
// TESTING
//  - Fixed priority: dreq = 4'b0110, mask = 0, hlda one cycle after hrq
//    -> ch1 serviced first, dack = 4'b0010 in S2-S4.
//  - Single, ch2, is_read = 1, tc on 3rd word
//    -> three hrq cycles.
//    -> memr_n low S2-S4, iow_n low S3-S4 per word.
//    -> eop_out pulse after the 3rd S4.
//  - Block, ch0, tc on 4th word
//    -> hrq stays high, S1-S4 repeated 4x (16 clocks).
//    -> ld_temp_addr only in the first S1.
//  - Rotating: ch0 terminates, then dreq = 4'b0011
//    -> ch1 granted before ch0.
//  - Demand mode ch3: drop dreq in 2nd word's S3
//    -> exit to SI after that S4, no eop_out.
//    -> rst asserted in S3 -> all strobes 1, dack 0 immediately.

Source files
------------

// File: rtl/dma_channel_sequencer_if.sv
// ---------------------------------------------------------------------------
// dma_channel_sequencer_if
//   Groups the DMA sequencer's request, datapath-status, bus-handshake and
//   control/strobe signals.
//
//   Modports
//     master : the sequencer (drives hrq, aen, dack, strobes, datapath controls)
//     slave  : the environment (CPU/datapath side, drives requests and status)
//
//   Signals (sequencer view)
//     in : master_clr, cs_n, dreq[NUM_CH], request_reg[NUM_CH], mask_reg[NUM_CH],
//          rotating_priority, xfer_mode[2], is_read, tc, hlda
//          (eop_in_n only when EXT_EOP_EN is defined)
//     out: hrq, aen, dack[NUM_CH], active_ch[CH_W], ld_temp_addr,
//          ld_upper_address, ld_lower_address, addr_gen, memr_n, memw_n,
//          ior_n, iow_n, clr_sw_req[NUM_CH], eop_out
//
//   Optional feature macro: EXT_EOP_EN (adds the external end-of-process input).
// ---------------------------------------------------------------------------
interface dma_channel_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic              master_clr;
    logic              cs_n;
    logic [NUM_CH-1:0] dreq;
    logic [NUM_CH-1:0] request_reg;
    logic [NUM_CH-1:0] mask_reg;
    logic              rotating_priority;
    logic [1:0]        xfer_mode;
    logic              is_read;
    logic              tc;
    logic              hlda;
`ifdef EXT_EOP_EN
    logic              eop_in_n;
`endif

    logic              hrq;
    logic              aen;
    logic [NUM_CH-1:0] dack;
    logic [CH_W-1:0]   active_ch;
    logic              ld_temp_addr;
    logic              ld_upper_address;
    logic              ld_lower_address;
    logic              addr_gen;
    logic              memr_n;
    logic              memw_n;
    logic              ior_n;
    logic              iow_n;
    logic [NUM_CH-1:0] clr_sw_req;
    logic              eop_out;

    modport master (
`ifdef EXT_EOP_EN
        input  eop_in_n,
`endif
        input  master_clr, cs_n, dreq, request_reg, mask_reg, rotating_priority,
               xfer_mode, is_read, tc, hlda,
        output hrq, aen, dack, active_ch, ld_temp_addr, ld_upper_address,
               ld_lower_address, addr_gen, memr_n, memw_n, ior_n, iow_n,
               clr_sw_req, eop_out
    );

    modport slave (
`ifdef EXT_EOP_EN
        output eop_in_n,
`endif
        output master_clr, cs_n, dreq, request_reg, mask_reg, rotating_priority,
               xfer_mode, is_read, tc, hlda,
        input  hrq, aen, dack, active_ch, ld_temp_addr, ld_upper_address,
               ld_lower_address, addr_gen, memr_n, memw_n, ior_n, iow_n,
               clr_sw_req, eop_out
    );
endinterface

// File: rtl/dma_channel_sequencer.sv
// ---------------------------------------------------------------------------
// dma_channel_sequencer
//   Control FSM for the 4-channel DMA datapath. Arbitrates hardware (DREQ)
//   and software requests, runs the HRQ/HLDA hold handshake and steps
//   S1..S4 for every word transferred.
//
//   Ports
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     bus  : dma_channel_sequencer_if.master (requests, datapath status,
//            hold handshake, datapath load controls, DACK and bus strobes)
//
//   Every output is a flop loaded from the next-state decode, so outputs
//   line up with the state they belong to and no input reaches a strobe
//   combinationally.
//
//   Optional feature macro: EXT_EOP_EN
//     defined   : bus.eop_in_n (active low, 2-flop synchronised) sampled low
//                 in S2..S4 terminates the service at S4 like tc.
//     undefined : only tc terminates a service.
// ---------------------------------------------------------------------------
module dma_channel_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dma_channel_sequencer_if.master bus
);

    localparam logic [2:0] ST_SI = 3'd0;
    localparam logic [2:0] ST_S0 = 3'd1;
    localparam logic [2:0] ST_S1 = 3'd2;
    localparam logic [2:0] ST_S2 = 3'd3;
    localparam logic [2:0] ST_S3 = 3'd4;
    localparam logic [2:0] ST_S4 = 3'd5;

    localparam logic [1:0] MODE_DEMAND = 2'b00;
    localparam logic [1:0] MODE_BLOCK  = 2'b10;

    // Returns {found, index}; search begins at 'start' and wraps around.
    function automatic logic [CH_W:0] pickWinner(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0]   start);
        logic [CH_W:0]   res;
        logic [CH_W-1:0] idx;
        res = '0;
        // Walk from the farthest candidate down so the nearest one wins last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = start + CH_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_CH-1:0] oneHot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] r;
        r     = '0;
        r[ch] = 1'b1;
        return r;
    endfunction

    logic [2:0]        state;
    logic [2:0]        stateNext;
    logic [CH_W-1:0]   activeCh;
    logic [CH_W-1:0]   chNext;
    logic [CH_W-1:0]   prioPtr;
    logic [CH_W-1:0]   ptrNext;
    logic              firstWord;
    logic              firstNext;
    logic              swOnly;
    logic              swOnlyNext;
    logic              terminate;
    logic [NUM_CH-1:0] eff;
    logic [CH_W:0]     win;
    logic [CH_W-1:0]   winCh;
    logic [1:0]        modeEff;
    logic              extEop;
    logic              inXferNext;
    logic              inWriteNext;

`ifdef EXT_EOP_EN
    logic eopSync1;
    logic eopSync2;
    logic eopLatched;

    // Two-flop synchroniser for the asynchronous external EOP pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eopSync1 <= 1'b1;
            eopSync2 <= 1'b1;
        end else begin
            eopSync1 <= bus.eop_in_n;
            eopSync2 <= eopSync1;
        end
    end

    // Remembers an EOP seen in S2/S3 so it still terminates at S4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eopLatched <= 1'b0;
        end else if (bus.master_clr) begin
            eopLatched <= 1'b0;
        end else if ((state == ST_S2) || (state == ST_S3) || (state == ST_S4)) begin
            eopLatched <= eopLatched | ~eopSync2;
        end else begin
            eopLatched <= 1'b0;
        end
    end

    assign extEop = eopLatched | ~eopSync2;
`else
    assign extEop = 1'b0;
`endif

    assign eff     = (bus.dreq & ~bus.mask_reg) | bus.request_reg;
    assign win     = pickWinner(eff, bus.rotating_priority ? prioPtr : {CH_W{1'b0}});
    assign winCh   = win[CH_W-1:0];
    // A service started purely by a software request always runs as block.
    assign modeEff = swOnly ? MODE_BLOCK : bus.xfer_mode;

    // Next-state, channel latch, priority pointer and termination decode.
    always_comb begin
        stateNext  = state;
        chNext     = activeCh;
        ptrNext    = prioPtr;
        firstNext  = firstWord;
        swOnlyNext = swOnly;
        terminate  = 1'b0;
        case (state)
            ST_SI: begin
                if (win[CH_W] && bus.cs_n) begin
                    stateNext  = ST_S0;
                    chNext     = winCh;
                    firstNext  = 1'b1;
                    swOnlyNext = ~(bus.dreq[winCh] & ~bus.mask_reg[winCh]);
                end else begin
                    stateNext  = ST_SI;
                end
            end
            ST_S0: begin
                if (bus.hlda) begin
                    stateNext = ST_S1;
                end else if (!eff[activeCh]) begin
                    stateNext = ST_SI;
                end else begin
                    stateNext = ST_S0;
                end
            end
            ST_S1: begin
                stateNext = ST_S2;
                firstNext = 1'b0;
            end
            ST_S2: stateNext = ST_S3;
            ST_S3: stateNext = ST_S4;
            ST_S4: begin
                if (bus.tc || extEop) begin
                    terminate = 1'b1;
                    stateNext = ST_SI;
                    ptrNext   = activeCh + CH_W'(1);
                end else if (!bus.hlda) begin
                    stateNext = ST_SI;
                end else begin
                    case (modeEff)
                        MODE_DEMAND: stateNext = bus.dreq[activeCh] ? ST_S1 : ST_SI;
                        MODE_BLOCK:  stateNext = ST_S1;
                        default:     stateNext = ST_SI;
                    endcase
                end
            end
            default: stateNext = ST_SI;
        endcase
    end

    assign inXferNext  = (stateNext == ST_S2) || (stateNext == ST_S3) || (stateNext == ST_S4);
    assign inWriteNext = (stateNext == ST_S3) || (stateNext == ST_S4);

    // State, pointer and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SI;
            activeCh  <= '0;
            prioPtr   <= '0;
            firstWord <= 1'b0;
            swOnly    <= 1'b0;
        end else if (bus.master_clr) begin
            state     <= ST_SI;
            activeCh  <= '0;
            prioPtr   <= '0;
            firstWord <= 1'b0;
            swOnly    <= 1'b0;
        end else begin
            state     <= stateNext;
            activeCh  <= chNext;
            prioPtr   <= ptrNext;
            firstWord <= firstNext;
            swOnly    <= swOnlyNext;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.hrq              <= 1'b0;
            bus.aen              <= 1'b0;
            bus.dack             <= '0;
            bus.active_ch        <= '0;
            bus.ld_temp_addr     <= 1'b0;
            bus.ld_upper_address <= 1'b0;
            bus.ld_lower_address <= 1'b0;
            bus.addr_gen         <= 1'b0;
            bus.memr_n           <= 1'b1;
            bus.memw_n           <= 1'b1;
            bus.ior_n            <= 1'b1;
            bus.iow_n            <= 1'b1;
            bus.clr_sw_req       <= '0;
            bus.eop_out          <= 1'b0;
        end else if (bus.master_clr) begin
            bus.hrq              <= 1'b0;
            bus.aen              <= 1'b0;
            bus.dack             <= '0;
            bus.active_ch        <= '0;
            bus.ld_temp_addr     <= 1'b0;
            bus.ld_upper_address <= 1'b0;
            bus.ld_lower_address <= 1'b0;
            bus.addr_gen         <= 1'b0;
            bus.memr_n           <= 1'b1;
            bus.memw_n           <= 1'b1;
            bus.ior_n            <= 1'b1;
            bus.iow_n            <= 1'b1;
            bus.clr_sw_req       <= '0;
            bus.eop_out          <= 1'b0;
        end else begin
            bus.hrq              <= (stateNext != ST_SI);
            bus.aen              <= (stateNext == ST_S1) || inXferNext;
            bus.dack             <= inXferNext ? oneHot(chNext) : {NUM_CH{1'b0}};
            bus.active_ch        <= chNext;
            bus.ld_temp_addr     <= (stateNext == ST_S1) && firstNext;
            bus.ld_upper_address <= (stateNext == ST_S1);
            bus.ld_lower_address <= (stateNext == ST_S2);
            bus.addr_gen         <= (stateNext == ST_S4);
            bus.memr_n           <= ~(inXferNext & bus.is_read);
            bus.ior_n            <= ~(inXferNext & ~bus.is_read);
            bus.iow_n            <= ~(inWriteNext & bus.is_read);
            bus.memw_n           <= ~(inWriteNext & ~bus.is_read);
            bus.clr_sw_req       <= terminate ? oneHot(activeCh) : {NUM_CH{1'b0}};
            bus.eop_out          <= terminate;
        end
    end

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dma_channel_sequencer
//   Directed bench for dma_channel_sequencer. The CPU hold acknowledge is
//   modelled by returning hrq on the falling edge (hlda one cycle after hrq).
//   Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dma_channel_sequencer;

    logic clk;
    logic rst;
    logic hldaEn;
    int   vecCnt;
    int   errCnt;

    dma_channel_sequencer_if #(.NUM_CH(4), .CH_W(2)) bus ();

    dma_channel_sequencer #(.NUM_CH(4), .CH_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU model: grants the bus half a cycle after hrq is seen.
    always @(negedge clk) bus.hlda = bus.hrq & hldaEn;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {bus.memr_n, bus.memw_n, bus.ior_n, bus.iow_n};
    endfunction

    // Waits (bounded) for an S1 cycle, recognised by ld_upper_address.
    task automatic waitS1(input string tag);
        int n;
        n = 0;
        while (!bus.ld_upper_address && n < 30) begin
            tick();
            n++;
        end
        checkResult(tag, {31'd0, bus.ld_upper_address}, 32'd1);
    endtask

    initial begin
        vecCnt = 0;
        errCnt = 0;
        hldaEn = 1'b1;
        rst    = 1'b1;
        bus.master_clr        = 1'b0;
        bus.cs_n              = 1'b1;
        bus.dreq              = 4'b0000;
        bus.request_reg       = 4'b0000;
        bus.mask_reg          = 4'b0000;
        bus.rotating_priority = 1'b0;
        bus.xfer_mode         = 2'b01;
        bus.is_read           = 1'b1;
        bus.tc                = 1'b0;
        bus.hlda              = 1'b0;
`ifdef EXT_EOP_EN
        bus.eop_in_n          = 1'b1;
`endif
        tick();
        tick();
        // Reset state
        checkResult("rst_hrq",     {31'd0, bus.hrq}, 32'd0);
        checkResult("rst_aen",     {31'd0, bus.aen}, 32'd0);
        checkResult("rst_dack",    {28'd0, bus.dack}, 32'd0);
        checkResult("rst_strobes", {28'd0, strobes()}, 32'hF);
        checkResult("rst_eop",     {31'd0, bus.eop_out}, 32'd0);
        rst = 1'b0;
        tick();

        // Fixed priority, single mode: ch1 beats ch2
        bus.dreq = 4'b0110;
        waitS1("fix_s1");
        checkResult("fix_ch",    {30'd0, bus.active_ch}, 32'd1);
        checkResult("fix_ldtmp", {31'd0, bus.ld_temp_addr}, 32'd1);
        tick();
        checkResult("fix_s2_dack", {28'd0, bus.dack}, 32'h2);
        checkResult("fix_s2_strb", {28'd0, strobes()}, 32'h7);
        checkResult("fix_s2_ldlo", {31'd0, bus.ld_lower_address}, 32'd1);
        tick();
        checkResult("fix_s3_dack", {28'd0, bus.dack}, 32'h2);
        checkResult("fix_s3_strb", {28'd0, strobes()}, 32'h6);
        tick();
        checkResult("fix_s4_dack", {28'd0, bus.dack}, 32'h2);
        checkResult("fix_s4_agen", {31'd0, bus.addr_gen}, 32'd1);
        bus.dreq = 4'b0000;
        tick();
        checkResult("fix_end_hrq", {31'd0, bus.hrq}, 32'd0);
        checkResult("fix_end_eop", {31'd0, bus.eop_out}, 32'd0);
        checkResult("fix_end_agen", {31'd0, bus.addr_gen}, 32'd0);

        // Single mode ch2, memory-to-IO, tc on the 3rd word
        bus.dreq = 4'b0100;
        for (int w = 1; w <= 3; w++) begin
            waitS1("sgl_s1");
            checkResult("sgl_ch", {30'd0, bus.active_ch}, 32'd2);
            tick();
            checkResult("sgl_s2_dack", {28'd0, bus.dack}, 32'h4);
            checkResult("sgl_s2_strb", {28'd0, strobes()}, 32'h7);
            tick();
            checkResult("sgl_s3_strb", {28'd0, strobes()}, 32'h6);
            tick();
            checkResult("sgl_s4_strb", {28'd0, strobes()}, 32'h6);
            if (w == 3) begin
                bus.tc   = 1'b1;
                bus.dreq = 4'b0000;
            end
            tick();
            checkResult("sgl_hrq_drop", {31'd0, bus.hrq}, 32'd0);
            checkResult("sgl_eop", {31'd0, bus.eop_out}, (w == 3) ? 32'd1 : 32'd0);
            checkResult("sgl_clr", {28'd0, bus.clr_sw_req}, (w == 3) ? 32'h4 : 32'h0);
            bus.tc = 1'b0;
        end
        tick();
        checkResult("sgl_eop_pulse", {31'd0, bus.eop_out}, 32'd0);

        // Block mode ch0, IO-to-memory, tc on 4th word: 16 clocks with hrq held
        bus.xfer_mode = 2'b10;
        bus.is_read   = 1'b0;
        bus.dreq      = 4'b0001;
        waitS1("blk_s1");
        for (int c = 0; c < 16; c++) begin
            checkResult("blk_hrq",   {31'd0, bus.hrq}, 32'd1);
            checkResult("blk_ldtmp", {31'd0, bus.ld_temp_addr}, (c == 0) ? 32'd1 : 32'd0);
            checkResult("blk_ldup",  {31'd0, bus.ld_upper_address}, ((c % 4) == 0) ? 32'd1 : 32'd0);
            checkResult("blk_agen",  {31'd0, bus.addr_gen}, ((c % 4) == 3) ? 32'd1 : 32'd0);
            if (c == 15) begin
                bus.tc   = 1'b1;
                bus.dreq = 4'b0000;
            end
            tick();
        end
        checkResult("blk_eop", {31'd0, bus.eop_out}, 32'd1);
        checkResult("blk_clr", {28'd0, bus.clr_sw_req}, 32'h1);
        checkResult("blk_hrq_drop", {31'd0, bus.hrq}, 32'd0);
        bus.tc = 1'b0;

        // Rotating priority: ch0 terminated last, so ch1 wins over ch0
        bus.rotating_priority = 1'b1;
        bus.xfer_mode         = 2'b01;
        bus.dreq              = 4'b0011;
        waitS1("rot_s1a");
        checkResult("rot_first", {30'd0, bus.active_ch}, 32'd1);
        tick();
        tick();
        tick();
        bus.tc   = 1'b1;
        bus.dreq = 4'b0001;
        tick();
        checkResult("rot_eop", {31'd0, bus.eop_out}, 32'd1);
        checkResult("rot_clr", {28'd0, bus.clr_sw_req}, 32'h2);
        bus.tc = 1'b0;
        waitS1("rot_s1b");
        checkResult("rot_second", {30'd0, bus.active_ch}, 32'd0);
        tick();
        tick();
        tick();
        bus.dreq = 4'b0000;
        tick();
        checkResult("rot_end_hrq", {31'd0, bus.hrq}, 32'd0);
        bus.rotating_priority = 1'b0;

        // Software-only request on a single-mode channel runs as block
        bus.request_reg = 4'b0100;
        waitS1("sw_s1");
        checkResult("sw_ch", {30'd0, bus.active_ch}, 32'd2);
        tick();
        tick();
        tick();
        tick();
        checkResult("sw_loop_ldup", {31'd0, bus.ld_upper_address}, 32'd1);
        checkResult("sw_loop_hrq",  {31'd0, bus.hrq}, 32'd1);
        tick();
        tick();
        tick();
        bus.tc = 1'b1;
        tick();
        checkResult("sw_eop", {31'd0, bus.eop_out}, 32'd1);
        checkResult("sw_clr", {28'd0, bus.clr_sw_req}, 32'h4);
        bus.tc          = 1'b0;
        bus.request_reg = 4'b0000;
        tick();

        // Masked hardware request and cs_n low both hold off service
        bus.mask_reg = 4'b0001;
        bus.dreq     = 4'b0001;
        tick();
        tick();
        checkResult("mask_hrq", {31'd0, bus.hrq}, 32'd0);
        bus.mask_reg = 4'b0000;
        bus.cs_n     = 1'b0;
        tick();
        tick();
        tick();
        checkResult("csn_hrq", {31'd0, bus.hrq}, 32'd0);

        // Request withdrawn in S0 before hlda: back to SI, hrq drops
        hldaEn   = 1'b0;
        bus.cs_n = 1'b1;
        tick();
        checkResult("s0_hrq", {31'd0, bus.hrq}, 32'd1);
        bus.dreq = 4'b0000;
        tick();
        checkResult("s0_abort_hrq", {31'd0, bus.hrq}, 32'd0);
        hldaEn = 1'b1;
        tick();

        // Demand mode ch3: dreq drops in the 2nd word's S3
        bus.xfer_mode = 2'b00;
        bus.is_read   = 1'b0;
        bus.dreq      = 4'b1000;
        waitS1("dem_s1");
        checkResult("dem_ch", {30'd0, bus.active_ch}, 32'd3);
        tick();
        checkResult("dem_s2_strb", {28'd0, strobes()}, 32'hD);
        checkResult("dem_s2_dack", {28'd0, bus.dack}, 32'h8);
        tick();
        checkResult("dem_s3_strb", {28'd0, strobes()}, 32'h9);
        tick();
        tick();
        checkResult("dem_w2_ldup",  {31'd0, bus.ld_upper_address}, 32'd1);
        checkResult("dem_w2_ldtmp", {31'd0, bus.ld_temp_addr}, 32'd0);
        checkResult("dem_w2_hrq",   {31'd0, bus.hrq}, 32'd1);
        tick();
        tick();
        bus.dreq = 4'b0000;
        tick();
        checkResult("dem_s4_agen", {31'd0, bus.addr_gen}, 32'd1);
        tick();
        checkResult("dem_end_hrq", {31'd0, bus.hrq}, 32'd0);
        checkResult("dem_end_eop", {31'd0, bus.eop_out}, 32'd0);

        // Async reset asserted in S3
        bus.dreq = 4'b1000;
        waitS1("rst3_s1");
        tick();
        tick();
        checkResult("rst3_pre_strb", {28'd0, strobes()}, 32'h9);
        rst = 1'b1;
        #1;
        checkResult("rst3_strb", {28'd0, strobes()}, 32'hF);
        checkResult("rst3_dack", {28'd0, bus.dack}, 32'h0);
        checkResult("rst3_hrq",  {31'd0, bus.hrq}, 32'd0);
        checkResult("rst3_aen",  {31'd0, bus.aen}, 32'd0);
        bus.dreq = 4'b0000;
        tick();
        rst = 1'b0;
        tick();

        // Synchronous master clear in S2
        bus.dreq = 4'b0010;
        waitS1("mclr_s1");
        tick();
        checkResult("mclr_pre_dack", {28'd0, bus.dack}, 32'h2);
        bus.master_clr = 1'b1;
        bus.dreq       = 4'b0000;
        tick();
        checkResult("mclr_dack", {28'd0, bus.dack}, 32'h0);
        checkResult("mclr_strb", {28'd0, strobes()}, 32'hF);
        checkResult("mclr_hrq",  {31'd0, bus.hrq}, 32'd0);
        bus.master_clr = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
